// File: rtl/shared_data_pkg.sv
// Shared definitions for the SFP event/shared-data link (TX and RX sides).
package shared_data_pkg;

  localparam logic [7:0] K28_5       = 8'hBC;
  localparam logic [7:0] K28_2_START = 8'h5C;
  localparam logic [7:0] K28_1_STOP  = 8'h3C;
  localparam logic [7:0] BEACON      = 8'h7E;

  localparam int unsigned SEG_BYTES = 16;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StAddr,
    StData,
    StStop,
    StCsumHi,
    StCsumLo
  } frame_state_e;

  // 0xFFFF minus the 16-bit wrapping sum of the address and all data bytes.
  function automatic logic [15:0] seg_checksum(input logic [7:0]             addr,
                                               input logic [8*SEG_BYTES-1:0] data);
    logic [15:0] sum;
    sum = {8'h00, addr};
    for (int i = 0; i < SEG_BYTES; i++) begin
      sum = sum + {8'h00, data[8*i +: 8]};
    end
    return 16'hFFFF - sum;
  endfunction

endpackage

// File: rtl/shared_data_tx_framer.sv
// Segment framer: latches one segment and walks START, ADDR, DATA, STOP and the
// big-endian checksum, one byte per step strobe (one step per data slot).
module shared_data_tx_framer
  import shared_data_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     step,
  input  logic                     seg_valid,
  input  logic [7:0]               seg_addr,
  input  logic [8*SEG_BYTES-1:0]   seg_data,
  output logic                     seg_ready,
  output logic [7:0]               tx_byte,
  output logic                     tx_k
);

  localparam int unsigned IdxW = (SEG_BYTES > 1) ? $clog2(SEG_BYTES) : 1;

  frame_state_e    r_state;
  frame_state_e    w_state_nxt;
  logic [IdxW-1:0] r_idx;
  logic [IdxW-1:0] w_idx_nxt;
  logic [7:0]      r_addr;
  logic [7:0]      r_bytes [SEG_BYTES];
  logic [15:0]     r_csum;
  logic            w_accept;

  assign seg_ready = en && (r_state == StIdle);
  assign w_accept  = seg_valid && seg_ready;

  // State and byte index; losing en drops any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_idx   <= '0;
    end else if (!en) begin
      r_state <= StIdle;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Segment latch; checksum is computed once at accept time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
      r_csum <= '0;
      for (int i = 0; i < SEG_BYTES; i++) r_bytes[i] <= '0;
    end else if (!en) begin
      r_addr <= '0;
      r_csum <= '0;
      for (int i = 0; i < SEG_BYTES; i++) r_bytes[i] <= '0;
    end else if (w_accept) begin
      r_addr <= seg_addr;
      r_csum <= seg_checksum(seg_addr, seg_data);
      for (int i = 0; i < SEG_BYTES; i++) r_bytes[i] <= seg_data[8*i +: 8];
    end
  end

  // Next state: accept is independent of step, everything else moves on step.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      StIdle:   if (w_accept) w_state_nxt = StStart;
      StStart:  if (step) w_state_nxt = StAddr;
      StAddr:   if (step) begin
        w_state_nxt = StData;
        w_idx_nxt   = '0;
      end
      StData:   if (step) begin
        if (r_idx == IdxW'(SEG_BYTES - 1)) begin
          w_state_nxt = StStop;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + IdxW'(1);
        end
      end
      StStop:   if (step) w_state_nxt = StCsumHi;
      StCsumHi: if (step) w_state_nxt = StCsumLo;
      StCsumLo: if (step) w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  // Byte presented for the current data slot.
  always_comb begin
    tx_byte = 8'h00;
    tx_k    = 1'b0;
    case (r_state)
      StStart: begin
        tx_byte = K28_2_START;
        tx_k    = 1'b1;
      end
      StAddr:   tx_byte = r_addr;
      StData:   tx_byte = r_bytes[r_idx];
      StStop: begin
        tx_byte = K28_1_STOP;
        tx_k    = 1'b1;
      end
      StCsumHi: tx_byte = r_csum[15:8];
      StCsumLo: tx_byte = r_csum[7:0];
      default: begin
        tx_byte = 8'h00;
        tx_k    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shared_data_tx.sv
// Transmit-side framer for the SFP event/shared-data link. MSB byte carries
// commas and events, LSB byte alternates dbus (even words) and segment frames
// (odd words). Optional beacon events are enabled by SHARED_DATA_TX_BEACON_EN.
module shared_data_tx #(
  parameter int unsigned COMMA_PERIOD  = 4,
  parameter int unsigned SEG_BYTES     = 16,
  parameter int unsigned BEACON_PERIOD = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tx_ready,
  input  logic [7:0]             dbus,
  input  logic                   ev_valid,
  input  logic [7:0]             ev_code,
  output logic                   ev_ready,
  input  logic                   seg_valid,
  input  logic [7:0]             seg_addr,
  input  logic [8*SEG_BYTES-1:0] seg_data,
  output logic                   seg_ready,
  output logic [15:0]            tx_data,
  output logic [1:0]             tx_is_k
);

  import shared_data_pkg::K28_5;
`ifdef SHARED_DATA_TX_BEACON_EN
  import shared_data_pkg::BEACON;
`endif

  localparam int unsigned WW = (COMMA_PERIOD > 2) ? $clog2(COMMA_PERIOD) : 1;

  logic          w_live;
  logic [WW-1:0] r_w;
  logic          w_is_comma;
  logic          w_data_slot;
  logic          r_ev_pend;
  logic [7:0]    r_ev_code;
  logic          w_ev_emit;
  logic [7:0]    w_msb;
  logic          w_msb_k;
  logic [7:0]    w_lsb;
  logic          w_lsb_k;
  logic [7:0]    w_frm_byte;
  logic          w_frm_k;
  logic [15:0]   r_tx_data;
  logic [1:0]    r_tx_is_k;

  // Keeps handshakes low while reset is held, even if tx_ready is already up.
  assign w_live      = tx_ready && !rst;
  assign w_is_comma  = (r_w == '0);
  assign w_data_slot = r_w[0];
  assign ev_ready    = w_live && !r_ev_pend;
  assign w_ev_emit   = w_live && r_ev_pend && !w_is_comma;

  shared_data_tx_framer u_framer (
    .clk       (clk),
    .rst       (rst),
    .en        (w_live),
    .step      (w_live && w_data_slot),
    .seg_valid (seg_valid),
    .seg_addr  (seg_addr),
    .seg_data  (seg_data),
    .seg_ready (seg_ready),
    .tx_byte   (w_frm_byte),
    .tx_k      (w_frm_k)
  );

  // Word counter; held at zero while the transceiver is not ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_w <= '0;
    end else if (!tx_ready) begin
      r_w <= '0;
    end else begin
      r_w <= r_w + WW'(1);
    end
  end

  // One-deep event register; cannot accept while an event is pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ev_pend <= 1'b0;
      r_ev_code <= 8'h00;
    end else if (!tx_ready) begin
      r_ev_pend <= 1'b0;
      r_ev_code <= 8'h00;
    end else if (ev_valid && ev_ready) begin
      r_ev_pend <= 1'b1;
      r_ev_code <= ev_code;
    end else if (w_ev_emit) begin
      r_ev_pend <= 1'b0;
    end
  end

`ifdef SHARED_DATA_TX_BEACON_EN
  localparam int unsigned BW = (BEACON_PERIOD > 2) ? $clog2(BEACON_PERIOD) : 1;

  logic [BW-1:0] r_bcn;

  // Beacon phase counter, words modulo BEACON_PERIOD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcn <= '0;
    end else if (!tx_ready) begin
      r_bcn <= '0;
    end else if (r_bcn == BW'(BEACON_PERIOD - 1)) begin
      r_bcn <= '0;
    end else begin
      r_bcn <= r_bcn + BW'(1);
    end
  end
`endif

  // MSB priority: comma, then pending event, then beacon (if built), else idle.
  always_comb begin
    w_msb   = 8'h00;
    w_msb_k = 1'b0;
    if (w_is_comma) begin
      w_msb   = K28_5;
      w_msb_k = 1'b1;
    end else if (r_ev_pend) begin
      w_msb = r_ev_code;
`ifdef SHARED_DATA_TX_BEACON_EN
    end else if (r_bcn == '0) begin
      w_msb = BEACON;
`endif
    end
  end

  // LSB: dbus on even words, framer byte on odd words.
  always_comb begin
    w_lsb   = dbus;
    w_lsb_k = 1'b0;
    if (w_data_slot) begin
      w_lsb   = w_frm_byte;
      w_lsb_k = w_frm_k;
    end
  end

  // Registered outputs; forced to zero the cycle after tx_ready drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_data <= '0;
      r_tx_is_k <= '0;
    end else if (!tx_ready) begin
      r_tx_data <= '0;
      r_tx_is_k <= '0;
    end else begin
      r_tx_data <= {w_msb, w_lsb};
      r_tx_is_k <= {w_msb_k, w_lsb_k};
    end
  end

  assign tx_data = r_tx_data;
  assign tx_is_k = r_tx_is_k;

endmodule

// File: tb/tb_shared_data_tx.sv
// Scoreboard bench for shared_data_tx: a word-level reference model pushes the
// expected output word each cycle; it is popped and compared after the edge.
module tb_shared_data_tx;

  localparam int unsigned NB = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            tx_ready;
  logic [7:0]      dbus;
  logic            ev_valid;
  logic [7:0]      ev_code;
  logic            ev_ready;
  logic            seg_valid;
  logic [7:0]      seg_addr;
  logic [8*NB-1:0] seg_data;
  logic            seg_ready;
  logic [15:0]     tx_data;
  logic [1:0]      tx_is_k;

  always #5 clk = ~clk;

  shared_data_tx dut (
    .clk       (clk),
    .rst       (rst),
    .tx_ready  (tx_ready),
    .dbus      (dbus),
    .ev_valid  (ev_valid),
    .ev_code   (ev_code),
    .ev_ready  (ev_ready),
    .seg_valid (seg_valid),
    .seg_addr  (seg_addr),
    .seg_data  (seg_data),
    .seg_ready (seg_ready),
    .tx_data   (tx_data),
    .tx_is_k   (tx_is_k)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int          m_w = 0;
  int          m_bcn = 0;
  bit          m_pend = 0;
  logic [7:0]  m_code = 8'h00;
  logic [8:0]  m_frame[$];
  logic [17:0] sb[$];
  bit          m_seg_acc;
  bit          m_ev_acc;
  int          n_bcn_exp = 0;

  // Observation state
  int          obs_idx = 0;
  int          stop_at = -1;
  logic [7:0]  cap_hi;
  logic [15:0] cap_csum[$];
  int          lo_idx[$];
  int          start_idx[$];
  int          n_ev23 = 0;
  int          n_bcn_obs = 0;
  int          n_stop = 0;

  task automatic push_frame(input logic [7:0] a, input logic [8*NB-1:0] d);
    int s;
    s = a;
    m_frame.push_back(9'h15C);
    m_frame.push_back({1'b0, a});
    for (int i = 0; i < NB; i++) begin
      m_frame.push_back({1'b0, d[8*i +: 8]});
      s = s + d[8*i +: 8];
    end
    m_frame.push_back(9'h13C);
    s = 65535 - (s % 65536);
    m_frame.push_back({1'b0, s[15:8]});
    m_frame.push_back({1'b0, s[7:0]});
  endtask

  task automatic model_eval();
    logic [7:0] msb;
    logic [7:0] lsb;
    logic       mk;
    logic       lk;
    logic [8:0] fb;
    bit         er;
    bit         sr;
    msb = 8'h00; lsb = 8'h00; mk = 1'b0; lk = 1'b0;
    m_seg_acc = 0; m_ev_acc = 0;
    if (!tx_ready) begin
      er = 0; sr = 0;
      m_w = 0; m_bcn = 0; m_pend = 0;
      m_frame.delete();
    end else begin
      er = !m_pend;
      sr = (m_frame.size() == 0);
      if (m_w == 0) begin
        msb = 8'hBC; mk = 1'b1;
      end else if (m_pend) begin
        msb = m_code; m_pend = 0;
`ifdef SHARED_DATA_TX_BEACON_EN
      end else if (m_bcn == 0) begin
        msb = 8'h7E; n_bcn_exp++;
`endif
      end
      if (m_w % 2 == 0) begin
        lsb = dbus;
      end else if (m_frame.size() > 0) begin
        fb  = m_frame.pop_front();
        lsb = fb[7:0];
        lk  = fb[8];
      end
      if (ev_valid && er) begin
        m_pend = 1; m_code = ev_code; m_ev_acc = 1;
      end
      if (seg_valid && sr) begin
        push_frame(seg_addr, seg_data);
        m_seg_acc = 1;
      end
      m_w   = (m_w + 1) % 4;
      m_bcn = (m_bcn + 1) % 7;
    end
    check_eq("ev_ready", ev_ready, er);
    check_eq("seg_ready", seg_ready, sr);
    sb.push_back({mk, lk, msb, lsb});
  endtask

  task automatic observe();
    if (!tx_is_k[1] && tx_data[15:8] == 8'h23) n_ev23++;
    if (!tx_is_k[1] && tx_data[15:8] == shared_data_pkg::BEACON) n_bcn_obs++;
    if (tx_is_k[0] && tx_data[7:0] == 8'h5C) start_idx.push_back(obs_idx);
    if (tx_is_k[0] && tx_data[7:0] == 8'h3C) begin
      stop_at = obs_idx;
      n_stop++;
    end
    if (stop_at >= 0 && obs_idx == stop_at + 2) cap_hi = tx_data[7:0];
    if (stop_at >= 0 && obs_idx == stop_at + 4) begin
      cap_csum.push_back({cap_hi, tx_data[7:0]});
      lo_idx.push_back(obs_idx);
    end
    obs_idx++;
  endtask

  task automatic sb_compare();
    logic [17:0] e;
    check_eq("sb_depth", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq("tx_data", tx_data, e[15:0]);
      check_eq("tx_is_k", tx_is_k, e[17:16]);
    end
    observe();
  endtask

  // One clock: inputs are already set (after a negedge).
  task automatic tick();
    #1;
    model_eval();
    @(posedge clk);
    #1;
    sb_compare();
    @(negedge clk);
  endtask

  task automatic wait_acc(input string tag, input int budget, input bit is_seg);
    bit got;
    got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      got = is_seg ? m_seg_acc : m_ev_acc;
    end
    check_eq(tag, got, 1);
  endtask

  task automatic run(input int n, input bit rnd_dbus);
    for (int i = 0; i < n; i++) begin
      if (rnd_dbus) dbus = 8'($urandom);
      tick();
    end
  endtask

  logic [7:0] ref_b [NB] = '{8'hAD, 8'h74, 8'hAD, 8'h74, 8'h7A, 8'h34, 8'h74, 8'hAD,
                             8'hAD, 8'h74, 8'hAD, 8'h74, 8'h7A, 8'h34, 8'h74, 8'hAD};
  logic [7:0] ev_list [6] = '{8'h11, 8'h42, 8'h7F, 8'hA5, 8'h01, 8'hFE};

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stops_before;
    rst = 1'b1; tx_ready = 1'b1; dbus = 8'h00;
    ev_valid = 1'b0; ev_code = 8'h00;
    seg_valid = 1'b0; seg_addr = 8'h00; seg_data = '0;
    #12;
    check_eq("rst_tx_data", tx_data, 0);
    check_eq("rst_tx_is_k", tx_is_k, 0);
    check_eq("rst_ev_ready", ev_ready, 0);
    check_eq("rst_seg_ready", seg_ready, 0);
    @(negedge clk);
    rst = 1'b0;

    // Idle stream
    run(12, 0);

    // Reference frame
    seg_addr = 8'h04;
    for (int i = 0; i < NB; i++) seg_data[8*i +: 8] = ref_b[i];
    seg_valid = 1'b1;
    wait_acc("ref_accept", 10, 1);
    seg_valid = 1'b0;
    run(50, 1);
    check_eq("ref_csum_cnt", cap_csum.size(), 1);
    if (cap_csum.size() > 0) check_eq("ref_csum", cap_csum.pop_front(), 16'hF7D9);

    // Event plus dbus
    dbus = 8'h55;
    n_ev23 = 0;
    ev_code = 8'h23;
    ev_valid = 1'b1;
    wait_acc("ev23_accept", 10, 0);
    ev_valid = 1'b0;
    run(8, 0);
    check_eq("ev23_once", n_ev23, 1);
    for (int k = 0; k < 6; k++) begin
      ev_code = ev_list[k];
      ev_valid = 1'b1;
      wait_acc("ev_accept", 10, 0);
      ev_valid = 1'b0;
      run(k, 1);
    end
    run(4, 1);

    // Back-to-back segments
    cap_csum.delete(); lo_idx.delete(); start_idx.delete();
    seg_addr = 8'h01;
    for (int i = 0; i < NB; i++) seg_data[8*i +: 8] = 8'h01;
    seg_valid = 1'b1;
    wait_acc("b2b_accept1", 10, 1);
    seg_addr = 8'h02;
    for (int i = 0; i < NB; i++) seg_data[8*i +: 8] = 8'h02;
    wait_acc("b2b_accept2", 60, 1);
    seg_valid = 1'b0;
    run(50, 1);
    check_eq("b2b_csum_cnt", cap_csum.size(), 2);
    check_eq("b2b_start_cnt", start_idx.size(), 2);
    if (cap_csum.size() == 2) begin
      check_eq("b2b_csum1", cap_csum[0], 16'hFFEE);
      check_eq("b2b_csum2", cap_csum[1], 16'hFFDD);
    end
    if (start_idx.size() == 2 && lo_idx.size() > 0)
      check_eq("b2b_gap", start_idx[1] - lo_idx[0], 2);

    // tx_ready drop mid-DATA
    seg_addr = 8'h09;
    for (int i = 0; i < NB; i++) seg_data[8*i +: 8] = 8'($urandom);
    seg_valid = 1'b1;
    wait_acc("drop_accept", 10, 1);
    seg_valid = 1'b0;
    run(10, 1);
    stops_before = n_stop;
    tx_ready = 1'b0;
    run(3, 1);
    tx_ready = 1'b1;
    dbus = 8'h3A;
    tick();
    check_eq("recover_comma", {tx_is_k[1], tx_data[15:8]}, 9'h1BC);
    run(5, 1);
    check_eq("no_stop_on_drop", n_stop, stops_before);
    seg_addr = 8'h33;
    seg_valid = 1'b1;
    wait_acc("post_drop_accept", 4, 1);
    seg_valid = 1'b0;
    run(50, 1);

    // Long idle for beacon pattern
    run(30, 1);
    check_eq("beacon_cnt", n_bcn_obs, n_bcn_exp);
    check_eq("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
